// File: rtl/tinyriscv_pkg.sv
// tinyriscv_pkg: shared bus width and APB master bridge types
package tinyriscv_pkg;
  localparam int MemBus = 32;
  localparam int ApbTimeoutDefault = 16;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_mst_state_e;
endpackage

// File: rtl/apb4_intf.sv
// apb4_intf: APB4 bus signal bundle with master and slave views
interface apb4_intf import tinyriscv_pkg::*; ();
  logic [MemBus-1:0]   paddr;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [MemBus-1:0]   pwdata;
  logic [MemBus/8-1:0] pstrb;
  logic [2:0]          pprot;
  logic [MemBus-1:0]   prdata;
  logic                pready;
  logic                pslverr;
  modport master (output paddr, psel, penable, pwrite, pwdata, pstrb, pprot, input prdata, pready, pslverr);
  modport slave (input paddr, psel, penable, pwrite, pwdata, pstrb, pprot, output prdata, pready, pslverr);
endinterface

// File: rtl/apb4_master_bridge.sv
// apb4_master_bridge: single-outstanding core request to APB4 master with access timeout
module apb4_master_bridge import tinyriscv_pkg::*; #(
  parameter int         TIMEOUT_CYCLES = ApbTimeoutDefault,
  parameter logic [2:0] PPROT_VAL      = 3'b000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [MemBus-1:0]   req_addr_i,
  input  logic [MemBus-1:0]   req_wdata_i,
  input  logic [MemBus/8-1:0] req_strb_i,
  output logic                rsp_valid_o,
  output logic [MemBus-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  apb4_intf.master            apb_mst
);
  localparam int CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  apb_mst_state_e      state_q;
  logic [CntW-1:0]     cnt_q;
  logic [MemBus-1:0]   paddr_q, pwdata_q, rsp_rdata_q;
  logic [MemBus/8-1:0] pstrb_q;
  logic                psel_q, penable_q, pwrite_q, rsp_valid_q, rsp_err_q;
  logic                tmo;
  // this ACCESS cycle would be the TIMEOUT_CYCLES-th one without PREADY
  assign tmo = (TIMEOUT_CYCLES != 0) && (32'(cnt_q) == 32'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (req_valid_i) begin
          state_q  <= SETUP;
          psel_q   <= 1'b1;
          paddr_q  <= {req_addr_i[MemBus-1:2], 2'b00};
          pwrite_q <= req_we_i;
          pwdata_q <= req_wdata_i;
          pstrb_q  <= req_we_i ? req_strb_i : '0;
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
          cnt_q     <= '0;
        end
        ACCESS: if (apb_mst.pready || tmo) begin
          state_q     <= IDLE;
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= (apb_mst.pready && !pwrite_q) ? apb_mst.prdata : '0;
          rsp_err_q   <= apb_mst.pready ? apb_mst.pslverr : 1'b1;
        end else cnt_q <= cnt_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ready_o     = (state_q == IDLE);
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_rdata_o     = rsp_rdata_q;
  assign rsp_err_o       = rsp_err_q;
  assign apb_mst.paddr   = paddr_q;
  assign apb_mst.psel    = psel_q;
  assign apb_mst.penable = penable_q;
  assign apb_mst.pwrite  = pwrite_q;
  assign apb_mst.pwdata  = pwdata_q;
  assign apb_mst.pstrb   = pstrb_q;
  assign apb_mst.pprot   = PPROT_VAL;
endmodule

// File: tb/tb_apb4_master_bridge.sv
// tb_apb4_master_bridge: randomized APB bridge bench against a transaction-timing model
module tb_apb4_master_bridge;
  import tinyriscv_pkg::*;
  localparam int T = 4;
  typedef struct {int c; logic [31:0] rd; logic err;} rsp_t;
  logic clk = 0;
  logic rst = 1;
  logic req_valid = 0, req_we = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_strb = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int cyc = 0, errors = 0, checks = 0;
  int hs = -100, endc = -100, rdy_c = -1, rst_c = 1;
  logic [31:0] m_addr = 0, m_wdata = 0, s_rd = 0, l_rd = 0;
  logic [3:0] m_strb = 0;
  logic m_we = 0, s_err = 0, l_err = 0;
  rsp_t q[$];
  int obs_rsp_c = -1, obs_acc = 0;
  logic [31:0] obs_rd = 0, obs_addr = 0;
  logic [3:0] obs_strb = 0;
  logic obs_err = 0;
  int obs_hs[$];
  apb4_intf bus ();
  always #5 clk = ~clk;
  apb4_master_bridge #(.TIMEOUT_CYCLES(T), .PPROT_VAL(3'b010)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .apb_mst(bus)
  );
  function automatic logic busy(int c);
    return hs < c && c < endc;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", n, cyc, a, e);
    end
  endtask
  always @(negedge clk) if (cyc >= 1) begin : cmp
    logic ev;
    ev = q.size() > 0 && q[0].c == cyc;
    if (cyc == rst_c) begin
      l_rd = 0;
      l_err = 0;
      chk("rst_paddr", bus.paddr, 0);
      chk("rst_pwdata", bus.pwdata, 0);
      chk("rst_pstrb", bus.pstrb, 0);
      chk("rst_pwrite", bus.pwrite, 0);
    end
    if (ev) begin
      l_rd = q[0].rd;
      l_err = q[0].err;
      void'(q.pop_front());
    end
    chk("req_ready", req_ready, !busy(cyc));
    chk("psel", bus.psel, busy(cyc));
    chk("penable", bus.penable, busy(cyc) && cyc > hs + 1);
    chk("rsp_valid", rsp_valid, ev);
    chk("rsp_rdata", rsp_rdata, l_rd);
    chk("rsp_err", rsp_err, l_err);
    chk("pprot", bus.pprot, 3'b010);
    if (busy(cyc)) begin
      chk("paddr", bus.paddr, m_addr);
      chk("pwrite", bus.pwrite, m_we);
      chk("pwdata", bus.pwdata, m_wdata);
      chk("pstrb", bus.pstrb, m_strb);
    end
    if (rsp_valid) begin
      obs_rsp_c = cyc;
      obs_rd = rsp_rdata;
      obs_err = rsp_err;
    end
    if (bus.psel && !bus.penable) begin
      obs_addr = bus.paddr;
      obs_strb = bus.pstrb;
      obs_acc = 0;
    end
    if (bus.psel && bus.penable) obs_acc++;
    if (req_valid && req_ready) obs_hs.push_back(cyc);
  end
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask
  task automatic drive_slave();
    if (busy(cyc) && cyc > hs + 1) begin
      bus.pready = (cyc == rdy_c);
      bus.prdata = (cyc == rdy_c) ? s_rd : $urandom;
      bus.pslverr = (cyc == rdy_c) ? s_err : 1'($urandom);
    end else begin
      bus.pready = 1'($urandom);
      bus.prdata = $urandom;
      bus.pslverr = 1'($urandom);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive_slave();
      req_valid = busy(cyc) ? 1'($urandom) : 1'b0;
      req_we = 1'($urandom);
      req_addr = $urandom;
      req_wdata = $urandom;
      req_strb = 4'($urandom);
      step();
    end
  endtask
  // w = wait states before PREADY; beyond T-1 the bridge must time out
  task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int w, input logic e, input logic [31:0] r, output int h);
    logic to;
    int acc;
    h = -1;
    for (int i = 0; i < 50 && h < 0; i++) begin
      drive_slave();
      req_valid = 1;
      req_we = we;
      req_addr = a;
      req_wdata = d;
      req_strb = s;
      if (!busy(cyc)) begin
        to = T != 0 && w + 1 > T;
        acc = to ? T : w + 1;
        h = cyc;
        hs = cyc;
        endc = cyc + 2 + acc;
        rdy_c = to ? -1 : cyc + 2 + w;
        m_addr = {a[31:2], 2'b00};
        m_we = we;
        m_wdata = d;
        m_strb = we ? s : 4'h0;
        s_rd = r;
        s_err = e;
        q.push_back('{endc, (to || we) ? 32'h0 : r, to ? 1'b1 : e});
      end
      step();
    end
    if (h < 0) begin
      checks++;
      errors++;
      $display("FAIL handshake_wait cyc=%0d actual=none expected=handshake", cyc);
    end
  endtask
  task automatic reset_at();
    drive_slave();
    req_valid = 0;
    rst = 1;
    if (endc > cyc + 1) endc = cyc + 1;
    while (q.size() > 0 && q[$].c >= cyc + 1) void'(q.pop_back());
    rst_c = cyc + 1;
    step();
    rst = 0;
  endtask
  initial begin
    int h;
    bus.pready = 0;
    bus.prdata = 0;
    bus.pslverr = 0;
    step();
    step();
    rst = 0;
    idle(2);
    xfer(1, 32'h1000_0006, 32'hA5A5_0001, 4'hF, 0, 0, 32'h0, h);
    idle(3);
    chk("w_latency", obs_rsp_c - h, 3);
    chk("w_rdata", obs_rd, 0);
    chk("w_err", obs_err, 0);
    chk("w_paddr", obs_addr, 32'h1000_0004);
    chk("w_pstrb", obs_strb, 4'hF);
    xfer(0, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 3, 0, 32'h0000_00C3, h);
    idle(6);
    chk("r_latency", obs_rsp_c - h, 6);
    chk("r_rdata", obs_rd, 32'h0000_00C3);
    chk("r_access_cycles", obs_acc, 4);
    chk("r_pstrb", obs_strb, 0);
    xfer(0, 32'h2000_0010, 32'h0, 4'h0, 0, 1, 32'h55, h);
    idle(3);
    chk("slverr_err", obs_err, 1);
    chk("slverr_latency", obs_rsp_c - h, 3);
    chk("slverr_idle", req_ready, 1);
    xfer(0, 32'h3000_0000, 32'h0, 4'h0, 6, 0, 32'h77, h);
    idle(8);
    chk("tmo_latency", obs_rsp_c - h, 6);
    chk("tmo_err", obs_err, 1);
    chk("tmo_rdata", obs_rd, 0);
    chk("tmo_access_cycles", obs_acc, 4);
    xfer(0, 32'h3000_0000, 32'h0, 4'h0, 3, 0, 32'h77, h);
    idle(8);
    chk("tmo_ready_latency", obs_rsp_c - h, 6);
    chk("tmo_ready_err", obs_err, 0);
    chk("tmo_ready_rdata", obs_rd, 32'h77);
    xfer(0, 32'h4000_0008, 32'h0, 4'h0, 5, 0, 32'h99, h);
    idle(1);
    reset_at();
    idle(8);
    chk("abort_no_rsp", obs_rsp_c < h, 1);
    xfer(1, 32'h4000_0000, 32'h1234, 4'h3, 1, 0, 32'h0, h);
    idle(6);
    chk("abort_next_latency", obs_rsp_c - h, 4);
    chk("abort_next_err", obs_err, 0);
    obs_hs.delete();
    for (int i = 0; i < 3; i++) xfer(1, 32'h5000_0000 + 32'(4 * i), $urandom, 4'hF, 0, 0, 32'h0, h);
    idle(4);
    chk("b2b_count", obs_hs.size(), 3);
    if (obs_hs.size() == 3) begin
      chk("b2b_gap1", obs_hs[1] - obs_hs[0], 3);
      chk("b2b_gap2", obs_hs[2] - obs_hs[1], 3);
    end
    repeat (300) begin
      xfer(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 6), 1'($urandom), $urandom, h);
      if ($urandom_range(0, 19) == 0) begin
        idle($urandom_range(0, 3));
        reset_at();
      end
      idle($urandom_range(0, 2));
    end
    idle(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
